// File: rtl/dff_stim_checker.sv
// LFSR stimulus driver and q checker for a single D flip-flop under test.
// A start edge drives N_VECTORS vectors, drains one cycle, then reports in DONE until the next start.
module dff_stim_checker #(
    parameter int          N_VECTORS = 16,
    parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       q_in,
    output logic       d_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic       mismatch,
    output logic [7:0] err_count,
    output logic [7:0] first_err_idx
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    // An all-zero seed would lock the LFSR, so it is swapped for 8'h01.
    localparam logic [7:0] SEED   = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
    localparam logic [7:0] N_LAST = 8'(N_VECTORS);

    function automatic logic [7:0] lfsr_next(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    state_t     state;
    state_t     state_nxt;
    logic [7:0] lfsr;
    logic [7:0] vec_cnt;
    logic [7:0] exp_idx;
    logic       exp_q;
    logic       exp_vld;
    logic       launch;
    logic       miss;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    launch    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (vec_cnt == N_LAST) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN:   state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    assign miss = exp_vld && (q_in != exp_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_out         <= 1'b0;
            mismatch      <= 1'b0;
            err_count     <= 8'h00;
            first_err_idx <= 8'hFF;
            lfsr          <= SEED;
            vec_cnt       <= 8'h00;
            exp_q         <= 1'b0;
            exp_vld       <= 1'b0;
            exp_idx       <= 8'h00;
        end else begin
            // The DUT captures d_out on this edge, so q_in matches it one cycle later.
            exp_q    <= d_out;
            exp_vld  <= (state == RUN);
            exp_idx  <= vec_cnt - 8'd1;
            mismatch <= miss;

            if (miss) begin
                if (err_count != 8'hFF) begin
                    err_count <= err_count + 8'd1;
                end
                if (err_count == 8'h00) begin
                    first_err_idx <= exp_idx;
                end
            end

            // Launch only happens in IDLE/DONE where exp_vld is low, so it never races a compare.
            if (launch) begin
                d_out         <= SEED[7];
                lfsr          <= lfsr_next(SEED);
                vec_cnt       <= 8'd1;
                err_count     <= 8'h00;
                first_err_idx <= 8'hFF;
            end else if (state == RUN) begin
                if (vec_cnt == N_LAST) begin
                    d_out <= 1'b0;
                end else begin
                    d_out   <= lfsr[7];
                    lfsr    <= lfsr_next(lfsr);
                    vec_cnt <= vec_cnt + 8'd1;
                end
            end
        end
    end

    assign busy = (state == RUN) || (state == DRAIN);
    assign done = (state == DONE);
    assign pass = (state == DONE) && (err_count == 8'h00);

endmodule

// File: tb/tb_dff_stim_checker.sv
// Bench for dff_stim_checker: a behavioural flip-flop sits under each checker instance,
// and q_in can be inverted or flipped for one cycle to inject faults.
module tb_dff_stim_checker;

    localparam int N0 = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start0 = 1'b0;
    logic       start1 = 1'b0;
    logic       inv = 1'b0;
    logic       flip = 1'b0;
    logic       dq0 = 1'b0;
    logic       dq1 = 1'b0;
    logic       q_in0;

    logic       d_out0, busy0, done0, pass0, mismatch0;
    logic [7:0] err_count0, first_err_idx0;
    logic       d_out1, busy1, done1, pass1, mismatch1;
    logic [7:0] err_count1, first_err_idx1;

    int checks = 0;
    int failures = 0;

    bit exp_dq[$];
    bit obs_dq[$];

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        dq0 <= d_out0;
        dq1 <= d_out1;
    end

    assign q_in0 = dq0 ^ inv ^ flip;

    dff_stim_checker #(.N_VECTORS(N0), .LFSR_SEED(8'hA5)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .q_in(q_in0),
        .d_out(d_out0), .busy(busy0), .done(done0), .pass(pass0), .mismatch(mismatch0),
        .err_count(err_count0), .first_err_idx(first_err_idx0)
    );

    dff_stim_checker #(.N_VECTORS(1), .LFSR_SEED(8'h00)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .q_in(dq1),
        .d_out(d_out1), .busy(busy1), .done(done1), .pass(pass1), .mismatch(mismatch1),
        .err_count(err_count1), .first_err_idx(first_err_idx1)
    );

    function automatic logic [7:0] model_next(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    // Starts a run on dut0; expected d values are queued when start is driven,
    // observed d values are queued as the DUT produces them.
    task automatic run_dut0(input bit inv_en, input int flip_cyc, input int restart_cyc,
                            output int pulses, output int first_pulse, output int done_cyc);
        logic [7:0] l;
        exp_dq.delete();
        obs_dq.delete();
        pulses = 0;
        first_pulse = -1;
        done_cyc = -1;
        l = 8'hA5;
        @(negedge clk);
        for (int i = 0; i < N0; i++) begin
            exp_dq.push_back(l[7]);
            l = model_next(l);
        end
        start0 = 1'b1;
        inv = inv_en;
        @(posedge clk);
        @(negedge clk);
        start0 = 1'b0;
        for (int cyc = 0; cyc < N0 + 40; cyc++) begin
            if (cyc < N0) obs_dq.push_back(d_out0);
            if (mismatch0) begin
                pulses++;
                if (first_pulse < 0) first_pulse = cyc;
            end
            start0 = (cyc == restart_cyc);
            flip = (cyc == flip_cyc);
            if (done0) begin
                done_cyc = cyc;
                break;
            end
            @(negedge clk);
        end
        start0 = 1'b0;
        flip = 1'b0;
    endtask

    task automatic test_reset;
        #12;
        checks++;
        if ({d_out0, busy0, done0, pass0, mismatch0, err_count0, first_err_idx0} !==
            {5'b00000, 8'h00, 8'hFF}) begin
            failures++;
            $display("FAIL reset_outputs got d=%b busy=%b done=%b pass=%b mm=%b err=%0d idx=%h want 0,0,0,0,0,0,ff",
                     d_out0, busy0, done0, pass0, mismatch0, err_count0, first_err_idx0);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy0, done0} !== 2'b00) begin
            failures++;
            $display("FAIL idle_hold got busy=%b done=%b want 0,0", busy0, done0);
        end
    endtask

    task automatic check_sequence(input string name);
        checks++;
        if (obs_dq.size() != exp_dq.size()) begin
            failures++;
            $display("FAIL %s_len got %0d want %0d", name, obs_dq.size(), exp_dq.size());
        end
        while (exp_dq.size() > 0 && obs_dq.size() > 0) begin
            bit e, o;
            int idx;
            idx = N0 - exp_dq.size();
            e = exp_dq.pop_front();
            o = obs_dq.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL %s_d[%0d] got %b want %b", name, idx, o, e);
            end
        end
    endtask

    task automatic test_clean;
        int pulses, fp, dc;
        bit o0, o1, o2;
        run_dut0(1'b0, -1, -1, pulses, fp, dc);
        o0 = obs_dq[0]; o1 = obs_dq[1]; o2 = obs_dq[2];
        checks++;
        if ({o0, o1, o2} !== 3'b101) begin
            failures++;
            $display("FAIL clean_first3 got %b%b%b want 101", o0, o1, o2);
        end
        check_sequence("clean");
        checks++;
        if (dc !== N0 + 1) begin
            failures++;
            $display("FAIL clean_done_cycle got %0d want %0d", dc, N0 + 1);
        end
        checks++;
        if ({err_count0, pass0, first_err_idx0, 8'(pulses)} !== {8'd0, 1'b1, 8'hFF, 8'd0}) begin
            failures++;
            $display("FAIL clean_result got err=%0d pass=%b idx=%h pulses=%0d want 0,1,ff,0",
                     err_count0, pass0, first_err_idx0, pulses);
        end
    endtask

    task automatic test_invert;
        int pulses, fp, dc;
        run_dut0(1'b1, -1, -1, pulses, fp, dc);
        inv = 1'b0;
        check_sequence("invert");
        checks++;
        if ({err_count0, pass0, first_err_idx0, 8'(pulses)} !== {8'd16, 1'b0, 8'h00, 8'd16}) begin
            failures++;
            $display("FAIL invert_result got err=%0d pass=%b idx=%h pulses=%0d want 16,0,00,16",
                     err_count0, pass0, first_err_idx0, pulses);
        end
    endtask

    task automatic test_single_flip;
        int pulses, fp, dc;
        // Vector 5 is compared at edge E0+7, i.e. q_in during cycle 6.
        run_dut0(1'b0, 6, -1, pulses, fp, dc);
        checks++;
        if ({err_count0, pass0, first_err_idx0, 8'(pulses)} !== {8'd1, 1'b0, 8'h05, 8'd1}) begin
            failures++;
            $display("FAIL flip_result got err=%0d pass=%b idx=%h pulses=%0d want 1,0,05,1",
                     err_count0, pass0, first_err_idx0, pulses);
        end
        checks++;
        if (fp !== 7) begin
            failures++;
            $display("FAIL flip_pulse_cycle got %0d want 7", fp);
        end
    endtask

    task automatic test_start_in_run;
        int pulses, fp, dc;
        run_dut0(1'b0, -1, 3, pulses, fp, dc);
        check_sequence("restart_ignored");
        checks++;
        if (dc !== N0 + 1) begin
            failures++;
            $display("FAIL restart_done_cycle got %0d want %0d", dc, N0 + 1);
        end
        checks++;
        if ({err_count0, pass0, first_err_idx0} !== {8'd0, 1'b1, 8'hFF}) begin
            failures++;
            $display("FAIL restart_cleared got err=%0d pass=%b idx=%h want 0,1,ff",
                     err_count0, pass0, first_err_idx0);
        end
    endtask

    task automatic test_back_to_back;
        int pulses, fp, dc;
        run_dut0(1'b0, -1, -1, pulses, fp, dc);
        check_sequence("back_to_back");
        checks++;
        if ({8'(dc), err_count0, pass0} !== {8'd17, 8'd0, 1'b1}) begin
            failures++;
            $display("FAIL b2b_result got done_cyc=%0d err=%0d pass=%b want 17,0,1", dc, err_count0, pass0);
        end
    endtask

    task automatic test_reset_mid_run;
        int pulses, fp, dc;
        bit saw_done;
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start0 = 1'b0;
        repeat (7) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({d_out0, busy0, done0, pass0, mismatch0, err_count0, first_err_idx0} !==
            {5'b00000, 8'h00, 8'hFF}) begin
            failures++;
            $display("FAIL midrun_reset got d=%b busy=%b done=%b pass=%b mm=%b err=%0d idx=%h want 0,0,0,0,0,0,ff",
                     d_out0, busy0, done0, pass0, mismatch0, err_count0, first_err_idx0);
        end
        saw_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done0) saw_done = 1'b1;
        end
        rst = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (done0 || busy0) saw_done = 1'b1;
        end
        checks++;
        if (saw_done !== 1'b0) begin
            failures++;
            $display("FAIL midrun_no_done got activity=%b want 0", saw_done);
        end
        run_dut0(1'b0, -1, -1, pulses, fp, dc);
        check_sequence("after_reset");
        checks++;
        if ({8'(dc), err_count0, pass0, first_err_idx0} !== {8'd17, 8'd0, 1'b1, 8'hFF}) begin
            failures++;
            $display("FAIL after_reset_result got done_cyc=%0d err=%0d pass=%b idx=%h want 17,0,1,ff",
                     dc, err_count0, pass0, first_err_idx0);
        end
    endtask

    task automatic test_single_vector;
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start1 = 1'b0;
        checks++;
        if ({d_out1, busy1, done1} !== 3'b010) begin
            failures++;
            $display("FAIL n1_cycle0 got d=%b busy=%b done=%b want 0,1,0", d_out1, busy1, done1);
        end
        @(negedge clk);
        checks++;
        if ({busy1, done1} !== 2'b10) begin
            failures++;
            $display("FAIL n1_cycle1 got busy=%b done=%b want 1,0", busy1, done1);
        end
        @(negedge clk);
        checks++;
        if ({busy1, done1, pass1, err_count1, first_err_idx1} !== {3'b011, 8'h00, 8'hFF}) begin
            failures++;
            $display("FAIL n1_done got busy=%b done=%b pass=%b err=%0d idx=%h want 0,1,1,0,ff",
                     busy1, done1, pass1, err_count1, first_err_idx1);
        end
    endtask

    initial begin
        test_reset();
        test_clean();
        test_invert();
        test_single_flip();
        test_start_in_run();
        test_back_to_back();
        test_reset_mid_run();
        test_single_vector();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
